// File: rtl/frame_writer.sv
// frame_writer
// Queues pixel-write requests for a 160x120, 3-bit framebuffer and writes one
// pixel per clock. A clear request first drains the queue, then fills the
// whole screen with the captured colour, one address per clock.
//
// Parameters
//   FIFO_DEPTH      pixel FIFO entries, power of two, 2..32
// Ports
//   clk_i           single clock, rising edge
//   reset_i         asynchronous active-high reset
//   plot_i          pixel-write request, qualified by x_i/y_i/colour_i
//   x_i, y_i        pixel column (0..159) and row (0..119)
//   colour_i        pixel value
//   ready_o         registered; a request is taken on any edge with plot_i && ready_o
//   clear_i         fill-screen request, sampled every edge
//   clear_colour_i  fill value, captured together with clear_i
//   busy_o          registered; high whenever the writer is not idle
//   mem_addr_o      framebuffer write address (y*160+x)
//   mem_data_o      framebuffer write data
//   mem_we_o        framebuffer write strobe, one write per high cycle
//   drop_count_o    saturating count of out-of-range requests
//                   (only when FRAME_WRITER_DROP_CNT_EN is defined)
//
// Build option
//   FRAME_WRITER_DROP_CNT_EN  adds the drop_count_o port and its counter;
//                             out-of-range requests are discarded either way.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | FIFO empty, no clear pending
// S_DRAIN | FIFO non-empty, popping one entry per edge
// S_FLUSH | clear pending, FIFO still draining
// S_CLEAR | sequential fill of addresses 0..19199

module frame_writer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        plot_i,
   input  logic [7:0]  x_i,
   input  logic [6:0]  y_i,
   input  logic [2:0]  colour_i,
   output logic        ready_o,
   input  logic        clear_i,
   input  logic [2:0]  clear_colour_i,
   output logic        busy_o,
   output logic [14:0] mem_addr_o,
   output logic [2:0]  mem_data_o,
   output logic        mem_we_o
`ifdef FRAME_WRITER_DROP_CNT_EN
   ,
   output logic [7:0]  drop_count_o
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
   localparam logic [14:0]   LAST_ADDR = 15'd19199;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_FLUSH,
      S_CLEAR
   } state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [14:0]    fill_q, fill_d;
   logic [2:0]     fill_colour_q, fill_colour_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           we_q, we_d;
   logic [14:0]    addr_q, addr_d;
   logic [2:0]     data_q, data_d;

   // entry layout: {y[6:0], x[7:0], colour[2:0]}
   logic [17:0]    fifo_mem [FIFO_DEPTH];

   logic           accept;
   logic           in_range;
   logic           push;
   logic           pop;
   logic [17:0]    rd_entry;
   logic [6:0]     rd_y;
   logic [7:0]     rd_x;
   logic [2:0]     rd_colour;
   logic [14:0]    pix_addr;

   assign accept    = plot_i & ready_q;
   assign in_range  = (x_i < 8'd160) && (y_i < 7'd120);
   assign push      = accept & in_range;
   assign pop       = (count_q != '0) && ((state_q == S_DRAIN) || (state_q == S_FLUSH));

   assign rd_entry  = fifo_mem[rd_ptr_q];
   assign rd_y      = rd_entry[17:11];
   assign rd_x      = rd_entry[10:3];
   assign rd_colour = rd_entry[2:0];
   // y*160 + x without a multiplier: y*128 + y*32 + x, max 19199 fits 15 bits
   assign pix_addr  = ({8'd0, rd_y} << 7) + ({8'd0, rd_y} << 5) + {7'd0, rd_x};

   always_comb begin
      wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      state_d       = state_q;
      fill_d        = fill_q;
      fill_colour_d = fill_colour_q;

      unique case (state_q)
         S_IDLE, S_DRAIN: begin
            if (clear_i) begin
               fill_colour_d = clear_colour_i;
               // a plot taken on this same edge is still written before the fill
               state_d = (count_d == '0) ? S_CLEAR : S_FLUSH;
            end else if (count_d != '0) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (count_d == '0) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (fill_q == LAST_ADDR) begin
               state_d = S_IDLE;
               fill_d  = '0;
            end else begin
               fill_d  = fill_q + 15'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (count_d != FULL) && (state_d != S_FLUSH) && (state_d != S_CLEAR);
      busy_d  = (state_d != S_IDLE);

      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (pop) begin
         we_d   = 1'b1;
         addr_d = pix_addr;
         data_d = rd_colour;
      end else if (state_q == S_CLEAR) begin
         we_d   = 1'b1;
         addr_d = fill_q;
         data_d = fill_colour_q;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         fill_q        <= '0;
         fill_colour_q <= '0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         fill_q        <= fill_d;
         fill_colour_q <= fill_colour_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
      end
   end

   // storage needs no reset; only the pointers and count define validity
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= {y_i, x_i, colour_i};
   end

   assign ready_o    = ready_q;
   assign busy_o     = busy_q;
   assign mem_we_o   = we_q;
   assign mem_addr_o = addr_q;
   assign mem_data_o = data_q;

`ifdef FRAME_WRITER_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (accept && !in_range && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) drop_q <= '0;
      else         drop_q <= drop_d;
   end

   assign drop_count_o = drop_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        plot_i = 1'b0;
   logic [7:0]  x_i = '0;
   logic [6:0]  y_i = '0;
   logic [2:0]  colour_i = '0;
   logic        ready_o;
   logic        clear_i = 1'b0;
   logic [2:0]  clear_colour_i = '0;
   logic        busy_o;
   logic [14:0] mem_addr_o;
   logic [2:0]  mem_data_o;
   logic        mem_we_o;
`ifdef FRAME_WRITER_DROP_CNT_EN
   logic [7:0]  drop_count_o;
`endif

   frame_writer #(.FIFO_DEPTH(8)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .plot_i         (plot_i),
      .x_i            (x_i),
      .y_i            (y_i),
      .colour_i       (colour_i),
      .ready_o        (ready_o),
      .clear_i        (clear_i),
      .clear_colour_i (clear_colour_i),
      .busy_o         (busy_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_we_o       (mem_we_o)
`ifdef FRAME_WRITER_DROP_CNT_EN
      ,
      .drop_count_o   (drop_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        last;
      logic [14:0] addr;
      logic [2:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   bit  fill_pending = 1'b0;
   int  model_drops = 0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // scoreboard monitor: every observed write must match the oldest expected one
   initial begin
      wr_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (mem_we_o) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                        mem_addr_o, mem_data_o);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", int'(mem_addr_o), int'(e.addr));
               check("wr_data", int'(mem_data_o), int'(e.data));
               if (e.last) fill_pending = 1'b0;
            end
         end
      end
   end

   // reference model: a request taken when ready; in-range pixels land at y*160+x,
   // a clear honoured only when no fill is outstanding queues a whole-screen fill
   task automatic model_step(input bit acc, input int xx, input int yy, input int cc,
                             input bit clr, input int ccol);
      wr_t w;
      if (acc) begin
         if (xx < 160 && yy < 120) begin
            w.last = 1'b0;
            w.addr = 15'(yy * 160 + xx);
            w.data = 3'(cc);
            exp_q.push_back(w);
         end else if (model_drops < 255) begin
            model_drops++;
         end
      end
      if (clr && !fill_pending) begin
         fill_pending = 1'b1;
         for (int a = 0; a < 19200; a++) begin
            w.last = (a == 19199);
            w.addr = 15'(a);
            w.data = 3'(ccol);
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic drive(input bit p, input int xx, input int yy, input int cc,
                        input bit clr, input int ccol, output bit acc);
      @(negedge clk_i);
      plot_i         = p;
      x_i            = 8'(xx);
      y_i            = 7'(yy);
      colour_i       = 3'(cc);
      clear_i        = clr;
      clear_colour_i = 3'(ccol);
      acc            = p && ready_o;
      model_step(acc, xx, yy, cc, clr, ccol);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 0, acc);
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         idle(1);
         k++;
      end
      check("drain_timeout_left", exp_q.size(), 0);
   endtask

   initial begin
      bit acc;
      int bad;
      bit pulsed;
      bit found;

      // reset state, held independent of the clock
      #12;
      check("rst_ready", int'(ready_o), 0);
      check("rst_busy",  int'(busy_o), 0);
      check("rst_we",    int'(mem_we_o), 0);
      check("rst_addr",  int'(mem_addr_o), 0);
      check("rst_data",  int'(mem_data_o), 0);
`ifdef FRAME_WRITER_DROP_CNT_EN
      check("rst_drop",  int'(drop_count_o), 0);
`endif
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i);
      #2;
      check("ready_after_reset", int'(ready_o), 1);

      // single pixel: write strobe exactly two edges after acceptance
      drive(1'b1, 5, 3, 6, 1'b0, 0, acc);
      check("single_accept", int'(acc), 1);
      @(posedge clk_i);
      #2;
      check("single_we_edge1", int'(mem_we_o), 0);
      check("single_busy", int'(busy_o), 1);
      idle(1);
      @(posedge clk_i);
      #2;
      check("single_we_edge2", int'(mem_we_o), 1);
      check("single_addr", int'(mem_addr_o), 485);
      check("single_data", int'(mem_data_o), 6);
      wait_drain(20);
      idle(1);
      check("single_busy_idle", int'(busy_o), 0);

      // back-to-back plots on the last row
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, i, 119, i % 8, 1'b0, 0, acc);
         if (!acc) bad++;
      end
      check("b2b_ready_drops", bad, 0);
      wait_drain(40);

      // random mix of in-range and out-of-range plots with gaps
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 175)),
               int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 1'b0, 0, acc);
      end
      wait_drain(40);
      idle(1);
      check("rand_busy_idle", int'(busy_o), 0);
      check("rand_ready_idle", int'(ready_o), 1);

      // queued pixels, then clear with a simultaneous plot; re-clear mid-fill ignored
      for (int i = 0; i < 8; i++) drive(1'b1, i, 20, 7 - i, 1'b0, 0, acc);
      drive(1'b1, 9, 20, 5, 1'b1, 3, acc);
      check("clear_plot_accept", int'(acc), 1);
      bad = 0;
      pulsed = 1'b0;
      for (int k = 0; k < 25000; k++) begin
         @(negedge clk_i);
         plot_i = 1'b0;
         clear_i = 1'b0;
         if (exp_q.size() == 0) break;
         if (ready_o) bad++;
         if (!pulsed && mem_we_o && mem_addr_o == 15'd1000 && mem_data_o == 3'd3) begin
            pulsed = 1'b1;
            clear_i = 1'b1;
            clear_colour_i = 3'd5;
            model_step(1'b0, 0, 0, 0, 1'b1, 5);
         end
      end
      check("fill_ready_low_cycles", bad, 0);
      check("fill_reclear_seen", int'(pulsed), 1);
      check("fill_left", exp_q.size(), 0);
      check("fill_busy_end", int'(busy_o), 0);
      check("fill_ready_end", int'(ready_o), 1);
      idle(5);

      // asynchronous reset in the middle of a fill
      drive(1'b0, 0, 0, 0, 1'b1, 2, acc);
      found = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk_i);
         clear_i = 1'b0;
         if (mem_we_o && mem_addr_o == 15'd5000) begin
            found = 1'b1;
            break;
         end
      end
      check("fill_reached_5000", int'(found), 1);
      reset_i = 1'b1;
      exp_q.delete();
      fill_pending = 1'b0;
      #1;
      check("rst_mid_we", int'(mem_we_o), 0);
      check("rst_mid_busy", int'(busy_o), 0);
      check("rst_mid_ready", int'(ready_o), 0);
      check("rst_mid_addr", int'(mem_addr_o), 0);
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i);
      #2;
      check("rst_mid_ready_after", int'(ready_o), 1);
      idle(30);
      check("rst_mid_residual", exp_q.size(), 0);
      check("rst_mid_busy_after", int'(busy_o), 0);

`ifdef FRAME_WRITER_DROP_CNT_EN
      model_drops = 0;
      drive(1'b1, 160, 0, 1, 1'b0, 0, acc);
      drive(1'b1, 0, 120, 1, 1'b0, 0, acc);
      idle(3);
      check("drop_two", int'(drop_count_o), 2);
      for (int i = 0; i < 300; i++) drive(1'b1, 200, 5, 1, 1'b0, 0, acc);
      idle(2);
      check("drop_saturate", int'(drop_count_o), 255);
      check("drop_model", int'(drop_count_o), model_drops);
`endif

      idle(5);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
